// File: rtl/fpu_ss_result_arb.sv
// Result arbiter: merges non-stallable CSR writebacks (buffered in a small FIFO)
// with backpressured integer-destination FPU results into one result channel.
module fpu_ss_result_arb #(
   parameter int CSR_DEPTH = 2,
   parameter int ID_WIDTH  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                csr_wb_i,
   input  logic [4:0]          csr_wb_addr_i,
   input  logic [ID_WIDTH-1:0] csr_wb_id_i,
   input  logic [31:0]         csr_rdata_i,
   input  logic                fpu_valid_i,
   output logic                fpu_ready_o,
   input  logic [4:0]          fpu_rd_i,
   input  logic [ID_WIDTH-1:0] fpu_id_i,
   input  logic [31:0]         fpu_result_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [4:0]          result_rd_o,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [31:0]         result_data_o,
   output logic                result_we_o,
   output logic                csr_almost_full_o,
   output logic                csr_full_o,
   output logic                overflow_o
);

   localparam int CW = $clog2(CSR_DEPTH + 1);
   localparam int PW = (CSR_DEPTH > 1) ? $clog2(CSR_DEPTH) : 1;

   logic [4:0]          r_mem_rd   [CSR_DEPTH];
   logic [ID_WIDTH-1:0] r_mem_id   [CSR_DEPTH];
   logic [31:0]         r_mem_data [CSR_DEPTH];
   logic [PW-1:0]       r_rd_ptr;
   logic [PW-1:0]       r_wr_ptr;
   logic [CW-1:0]       r_count;
   logic                r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push_acc;
   logic w_push_drop;

   // Pointers wrap at CSR_DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(CSR_DEPTH - 1)) begin
         ptr_inc = {PW{1'b0}};
      end else begin
         ptr_inc = p + PW'(1);
      end
   endfunction

   assign w_empty     = (r_count == {CW{1'b0}});
   assign w_full      = (r_count == CW'(CSR_DEPTH));
   assign w_pop       = !w_empty && result_ready_i;
   // A push into a full FIFO only fits if the head leaves in the same cycle.
   assign w_push_acc  = csr_wb_i && (!w_full || w_pop);
   assign w_push_drop = csr_wb_i && w_full && !w_pop;

   // FIFO storage write
   always_ff @(posedge clk_i) begin
      if (w_push_acc) begin
         r_mem_rd[r_wr_ptr]   <= csr_wb_addr_i;
         r_mem_id[r_wr_ptr]   <= csr_wb_id_i;
         r_mem_data[r_wr_ptr] <= csr_rdata_i;
      end
   end

   // FIFO control state and sticky overflow
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_ptr   <= {PW{1'b0}};
         r_wr_ptr   <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_push_acc) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CW'(w_push_acc) - CW'(w_pop);
         if (w_push_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Output selection: buffered CSR results take strict priority over the FPU bypass.
   always_comb begin
      result_valid_o = 1'b0;
      result_rd_o    = 5'd0;
      result_id_o    = {ID_WIDTH{1'b0}};
      result_data_o  = 32'd0;
      fpu_ready_o    = 1'b0;
      if (!w_empty) begin
         result_valid_o = 1'b1;
         result_rd_o    = r_mem_rd[r_rd_ptr];
         result_id_o    = r_mem_id[r_rd_ptr];
         result_data_o  = r_mem_data[r_rd_ptr];
         fpu_ready_o    = 1'b0;
      end else begin
         result_valid_o = fpu_valid_i;
         fpu_ready_o    = result_ready_i;
         if (fpu_valid_i) begin
            result_rd_o   = fpu_rd_i;
            result_id_o   = fpu_id_i;
            result_data_o = fpu_result_i;
         end else begin
            result_rd_o   = 5'd0;
            result_id_o   = {ID_WIDTH{1'b0}};
            result_data_o = 32'd0;
         end
      end
   end

   assign result_we_o       = result_valid_o;
   assign csr_full_o        = w_full;
   assign csr_almost_full_o = (r_count >= CW'(CSR_DEPTH - 1));
   assign overflow_o        = r_overflow;

endmodule
